// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//
// Contents:
//   DEFAULT_BIT_PERIOD  clocks per serial bit when not overridden (10)
//   NUM_DATA_BITS       data bits per frame (8)
//   PERIOD_CNT_W        width of the clock-in-bit counter (covers 2..255)
//   BIT_CNT_W           width of the data-bit counter (covers 0..8)
//   uart_state_e        frame FSM states
//   uart_tx_dbg_t       transmitter debug view: FSM state and both counters
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_BIT_PERIOD = 10;
    localparam int NUM_DATA_BITS      = 8;
    localparam int PERIOD_CNT_W       = 8;
    localparam int BIT_CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } uart_state_e;

    typedef struct packed {
        uart_state_e             state;
        logic [PERIOD_CNT_W-1:0] period_cnt;
        logic [BIT_CNT_W-1:0]    bit_cnt;
    } uart_tx_dbg_t;

endpackage

// File: rtl/flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter -- counter that runs 1..rollover_val and wraps back to 1.
//
// Ports:
//   clk             in   system clock, rising edge
//   n_rst           in   asynchronous active-low reset (count -> 0)
//   clear_i         in   synchronous clear to 0, dominates count_enable_i
//   count_enable_i  in   advance the count this cycle
//   rollover_val_i  in   terminal count
//   count_o         out  current count
//   rollover_flag_o out  high while count_o equals rollover_val_i
// -----------------------------------------------------------------------------
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear_i,
    input  logic                    count_enable_i,
    input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
    output logic [NUM_CNT_BITS-1:0] count_o,
    output logic                    rollover_flag_o
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_enable_i) begin
            // Wrap to 1, not 0: 0 only ever means "cleared / not running".
            if (count_q == rollover_val_i) begin
                count_d = NUM_CNT_BITS'(1);
            end else begin
                count_d = count_q + NUM_CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o         = count_q;
    assign rollover_flag_o = (count_q == rollover_val_i);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- 8N1 UART transmitter.
//
// Ports:
//   clk         in   system clock, rising edge
//   n_rst       in   asynchronous active-low reset
//   tx_start    in   send request
//   tx_data     in   byte to send, captured with the accepted request
//   tx_busy     out  frame in progress
//   tx_done     out  one-cycle pulse in the first idle cycle after a frame
//   serial_out  out  serial line, idle high (registered)
//   dbg_o       out  FSM state and counter values
//
// Handshake: a request is accepted on the rising edge where tx_start=1 and
// tx_busy=0; tx_busy is high from the next cycle until the frame ends.
// Requests while tx_busy=1 are dropped, not queued. tx_busy is already low in
// the tx_done cycle, so a request there chains frames with no idle gap.
//
// Frame: start bit (0), 8 data bits LSB first, stop bit (1), each held for
// BIT_PERIOD clocks.
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         tx_start,
    input  logic [7:0]   tx_data,
    output logic         tx_busy,
    output logic         tx_done,
    output logic         serial_out,
    output uart_tx_dbg_t dbg_o
);

    uart_state_e state_q;
    uart_state_e state_d;
    logic [NUM_DATA_BITS-1:0] shift_q;
    logic [NUM_DATA_BITS-1:0] shift_d;
    logic serial_q;
    logic serial_d;
    logic busy_q;
    logic busy_d;
    logic done_q;
    logic done_d;

    logic                    period_clear;
    logic                    period_roll;
    logic [PERIOD_CNT_W-1:0] period_cnt;
    logic                    bit_clear;
    logic                    bit_roll;
    logic [BIT_CNT_W-1:0]    bit_cnt;

    // Both counters are cleared from the next state so the period counter
    // reads 1 in the first cycle of the start bit and 0 again in the first
    // idle cycle; period_roll then marks the last cycle of every bit.
    assign period_clear = (state_d == IDLE);
    assign bit_clear    = (state_d != DATA_BITS);

    flex_counter #(
        .NUM_CNT_BITS (PERIOD_CNT_W)
    ) u_period_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear_i         (period_clear),
        .count_enable_i  (1'b1),
        .rollover_val_i  (PERIOD_CNT_W'(BIT_PERIOD)),
        .count_o         (period_cnt),
        .rollover_flag_o (period_roll)
    );

    flex_counter #(
        .NUM_CNT_BITS (BIT_CNT_W)
    ) u_bit_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear_i         (bit_clear),
        .count_enable_i  (period_roll),
        .rollover_val_i  (BIT_CNT_W'(NUM_DATA_BITS)),
        .count_o         (bit_cnt),
        .rollover_flag_o (bit_roll)
    );

    // Next-state and shift-register logic.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d = START_BIT;
                    shift_d = tx_data;
                end
            end
            START_BIT: begin
                if (period_roll) begin
                    state_d = DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (period_roll) begin
                    shift_d = {1'b0, shift_q[NUM_DATA_BITS-1:1]};
                    if (bit_roll) begin
                        state_d = STOP_BIT;
                    end
                end
            end
            STOP_BIT: begin
                if (period_roll) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered line changes
    // on the same edge as the state it belongs to.
    always_comb begin
        serial_d = 1'b1;
        unique case (state_d)
            IDLE:      serial_d = 1'b1;
            START_BIT: serial_d = 1'b0;
            DATA_BITS: serial_d = shift_d[0];
            STOP_BIT:  serial_d = 1'b1;
            default:   serial_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP_BIT) && period_roll;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign serial_out = serial_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

    assign dbg_o = '{state: state_q, period_cnt: period_cnt, bit_cnt: bit_cnt};

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- directed bench for uart_tx. Two instances: BIT_PERIOD=10 and
// BIT_PERIOD=2. Inputs change on the falling edge, outputs are sampled on the
// falling edge; "cycle c" of a frame is the value after the c-th rising edge
// following the accepting edge.
// -----------------------------------------------------------------------------
module tb_uart_tx;
    import uart_pkg::*;

    localparam int BP_A = 10;
    localparam int BP_B = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic       tx_start   = 1'b0;
    logic       tx_start_b = 1'b0;
    logic [7:0] tx_data    = 8'h00;

    logic         busy_a, done_a, serial_a;
    logic         busy_b, done_b, serial_b;
    uart_tx_dbg_t dbg_a, dbg_b;

    uart_tx #(.BIT_PERIOD(BP_A)) dut_a (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (busy_a),
        .tx_done    (done_a),
        .serial_out (serial_a),
        .dbg_o      (dbg_a)
    );

    uart_tx #(.BIT_PERIOD(BP_B)) dut_b (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_start   (tx_start_b),
        .tx_data    (tx_data),
        .tx_busy    (busy_b),
        .tx_done    (done_b),
        .serial_out (serial_b),
        .dbg_o      (dbg_b)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [2:0] exp_q[$];   // per cycle: {serial, busy, done}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_expected(input logic [7:0] b, input int bp);
        exp_q.delete();
        for (int c = 1; c <= 10 * bp + 1; c++) begin
            logic s;
            if (c <= bp)          s = 1'b0;
            else if (c <= 9 * bp) s = b[3'((c - bp - 1) / bp)];
            else                  s = 1'b1;
            exp_q.push_back({s, (c <= 10 * bp), (c == 10 * bp + 1)});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic launch(input logic sel, input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        if (sel) tx_start_b = 1'b1;
        else     tx_start   = 1'b1;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_serial_a", 32'(serial_a), 32'd1);
            chk("idle_busy_a",   32'(busy_a),   32'd0);
            chk("idle_done_a",   32'(done_a),   32'd0);
            chk("idle_done_b",   32'(done_b),   32'd0);
        end
    endtask

    // Runs one frame from its accepting edge. keep_start holds tx_start high
    // through the frame and swaps in next_b during the tx_done cycle;
    // inject_c pulses a 0x3C request mid-frame; abort_c drops n_rst.
    task automatic frame(input logic sel, input logic [7:0] b, input logic keep_start,
                         input logic [7:0] next_b, input int inject_c, input int abort_c);
        int bp;
        logic [2:0] e;
        logic [2:0] o;
        int st;
        int pc;
        int bc;
        bp = sel ? BP_B : BP_A;
        build_expected(b, bp);
        @(posedge clk);
        for (int c = 1; c <= 10 * bp + 1; c++) begin
            @(negedge clk);
            if (c == 1 && !keep_start) begin
                if (sel) tx_start_b = 1'b0;
                else     tx_start   = 1'b0;
            end
            e = exp_q.pop_front();
            o = sel ? {serial_b, busy_b, done_b} : {serial_a, busy_a, done_a};
            chk("serial_out", 32'(o[2]), 32'(e[2]));
            chk("tx_busy",    32'(o[1]), 32'(e[1]));
            chk("tx_done",    32'(o[0]), 32'(e[0]));
            if (!sel) begin
                if (c <= bp)           st = 1;
                else if (c <= 9 * bp)  st = 2;
                else if (c <= 10 * bp) st = 3;
                else                   st = 0;
                pc = (c <= 10 * bp) ? ((c - 1) % bp) + 1 : 0;
                bc = (st == 2) ? ((c - bp - 1) / bp) + 1 : 0;
                chk("fsm_state",  32'(dbg_a.state),      32'(st));
                chk("period_cnt", 32'(dbg_a.period_cnt), 32'(pc));
                chk("bit_cnt",    32'(dbg_a.bit_cnt),    32'(bc));
            end
            if (c == inject_c) begin
                tx_start = 1'b1;
                tx_data  = 8'h3C;
            end
            if (c == inject_c + 1) tx_start = 1'b0;
            if (c == abort_c) begin
                n_rst = 1'b0;
                #1;
                chk("abort_serial", 32'(serial_a),    32'd1);
                chk("abort_busy",   32'(busy_a),      32'd0);
                chk("abort_done",   32'(done_a),      32'd0);
                chk("abort_state",  32'(dbg_a.state), 32'(IDLE));
                return;
            end
            if (c == 10 * bp + 1 && keep_start) tx_data = next_b;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] rb;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_serial_a", 32'(serial_a),         32'd1);
        chk("rst_busy_a",   32'(busy_a),           32'd0);
        chk("rst_done_a",   32'(done_a),           32'd0);
        chk("rst_state_a",  32'(dbg_a.state),      32'(IDLE));
        chk("rst_period_a", 32'(dbg_a.period_cnt), 32'd0);
        chk("rst_bitcnt_a", 32'(dbg_a.bit_cnt),    32'd0);
        chk("rst_serial_b", 32'(serial_b),         32'd1);
        chk("rst_busy_b",   32'(busy_b),           32'd0);
        n_rst = 1'b1;
        idle_check(2);

        // 0xA5: start 1-10, bits 1,0,1,0,0,1,0,1, stop 91-100, done at 101.
        launch(1'b0, 8'hA5);
        frame(1'b0, 8'hA5, 1'b0, 8'h00, -1, -1);
        idle_check(3);

        // 0x00 then 0xFF with tx_start held: second start bit at cycle 102.
        launch(1'b0, 8'h00);
        frame(1'b0, 8'h00, 1'b1, 8'hFF, -1, -1);
        frame(1'b0, 8'hFF, 1'b0, 8'h00, -1, -1);
        idle_check(3);

        // 0x81 with a 0x3C request at cycle 40: ignored, single tx_done.
        launch(1'b0, 8'h81);
        frame(1'b0, 8'h81, 1'b0, 8'h00, 40, -1);
        idle_check(5);

        // Reset at cycle 55 of a 0xC3 frame, then 0x5A.
        launch(1'b0, 8'hC3);
        frame(1'b0, 8'hC3, 1'b0, 8'h00, -1, 55);
        @(negedge clk);
        chk("in_rst_done",   32'(done_a),   32'd0);
        chk("in_rst_serial", 32'(serial_a), 32'd1);
        n_rst = 1'b1;
        idle_check(2);
        launch(1'b0, 8'h5A);
        frame(1'b0, 8'h5A, 1'b0, 8'h00, -1, -1);
        idle_check(2);

        // BIT_PERIOD=2, 0x01: 20-cycle frame, tx_done at cycle 21.
        launch(1'b1, 8'h01);
        frame(1'b1, 8'h01, 1'b0, 8'h00, -1, -1);
        @(negedge clk);
        chk("b_after_busy", 32'(busy_b),   32'd0);
        chk("b_after_done", 32'(done_b),   32'd0);
        chk("b_after_line", 32'(serial_b), 32'd1);

        // A few random bytes on each instance.
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            launch(1'b0, rb);
            frame(1'b0, rb, 1'b0, 8'h00, -1, -1);
            rb = 8'($urandom_range(0, 255));
            launch(1'b1, rb);
            frame(1'b1, rb, 1'b0, 8'h00, -1, -1);
        end
        idle_check(2);

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter BIT_PERIOD, default 10, clocks per serial bit (range 2..255).
REQ-002 SHALL provide port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL provide port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port tx_start  input  1  request to send tx_data; sampled only while tx_busy=0.
REQ-005 SHALL provide port tx_data  input  8  byte to send; captured in the tx_start accept cycle.
REQ-006 SHALL provide port tx_busy  output  1  high while a frame is in progress.
REQ-007 SHALL provide port tx_done  output  1  single-cycle pulse at frame completion.
REQ-008 SHALL provide port serial_out  output  1  serial line, idle high.

Function
REQ-009 Frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each held exactly BIT_PERIOD cycles.
REQ-010 FSM SHALL have states IDLE, START_BIT, DATA_BITS, STOP_BIT.
REQ-011 IDLE: serial_out=1, tx_busy=0; tx_start=1 at edge T SHALL load tx_data into an 8-bit shift register and enter START_BIT.
REQ-012 START_BIT SHALL drive serial_out=0 in cycles T+1..T+BIT_PERIOD, then enter DATA_BITS.
REQ-013 DATA_BITS SHALL drive shift register bit 0, shifting right once per BIT_PERIOD, for 8 bit periods, then enter STOP_BIT.
REQ-014 STOP_BIT SHALL drive serial_out=1 for BIT_PERIOD cycles, then return to IDLE.
REQ-015 tx_done SHALL be high for exactly one cycle, the first IDLE cycle after STOP_BIT (cycle T+10*BIT_PERIOD+1).
REQ-016 tx_busy SHALL be 1 in START_BIT, DATA_BITS and STOP_BIT, and 0 in IDLE, including the tx_done cycle.
REQ-017 tx_start during tx_busy=1 SHALL be ignored, with no queuing; tx_data changes during a frame SHALL NOT affect it.
REQ-018 tx_start in the tx_done cycle SHALL be accepted, giving back-to-back frames with no extra idle bit time.
REQ-019 Clock-in-bit counter SHALL count 1..BIT_PERIOD and wrap to 1; it SHALL be cleared in IDLE.
REQ-020 Bit counter SHALL count data bits 1..8, advance on each bit-period rollover in DATA_BITS, and be cleared outside DATA_BITS.
REQ-021 serial_out SHALL be registered, with no combinational path from tx_start or tx_data.

Reset
REQ-022 n_rst=0 SHALL asynchronously force IDLE, serial_out=1, tx_busy=0, tx_done=0, both counters=0 and shift register=0.
REQ-023 Reset mid-frame SHALL abort the frame without a tx_done pulse; the line SHALL be high on the next cycle.
REQ-024 After release, the first edge with tx_start=1 SHALL start a frame normally.

Structure
REQ-025 Shared package uart_pkg SHALL hold the state enum, DATA_BITS=8, and the default BIT_PERIOD=10, common to receiver and transmitter.
REQ-026 Both counters SHALL be instances of the existing flex_counter: the bit-period counter (rollover BIT_PERIOD, clear in IDLE) and the bit counter (rollover 8, enabled by the period rollover flag).
REQ-027 FSM, shift register and output registers SHALL reside in uart_tx; no other sub-module.

Verification
REQ-028 Reset, then tx_start with 0xA5 at cycle 0 -> serial_out 0 for cycles 1-10, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for cycles 91-100; tx_done at cycle 101.
REQ-029 Send 0x00 then 0xFF with tx_start held high through the tx_done cycle -> second start bit begins at cycle 102, with no gap.
REQ-030 Pulse tx_start with 0x3C at cycle 40 of a frame carrying 0x81 -> only 0x81 is sent, with a single tx_done.
REQ-031 Assert n_rst=0 at cycle 55 of a frame -> serial_out=1 and tx_busy=0 immediately, with no tx_done; next frame of 0x5A is correct.
REQ-032 Set BIT_PERIOD=2 and send 0x01 -> frame lasts 20 cycles and tx_done occurs at cycle 21.
REQ-033 Loop uart_tx into the team receiver with 256 random bytes -> every byte is received intact with no framing error.
